// File: rtl/table_loader_pkg.sv
// Shared types and sizing for the sine-table loader: FSM state encoding and table geometry.
package table_loader_pkg;

    localparam int unsigned TABLE_DEPTH    = 256;
    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned COUNT_W        = 9;
    localparam int unsigned IDX_W          = 2;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FINISH
    } state_t;

    // A load must cover between one word and the whole table.
    function automatic logic count_legal(input logic [COUNT_W-1:0] n);
        return (n != '0) && (n <= COUNT_W'(TABLE_DEPTH));
    endfunction

endpackage

// File: rtl/table_loader_byte_packer.sv
// Little-endian byte-to-word assembler; raises word_ready on the cycle the final byte is accepted.
module byte_packer
    import table_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        data,
    output logic              word_ready,
    output logic [DATA_W-1:0] word
);

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] asm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (clear) begin
            idx   <= '0;
            asm_q <= '0;
        end else if (accept) begin
            asm_q[{idx, 3'b000} +: 8] <= data;
            idx                       <= idx + 1'b1;
        end
    end

    // The word handed out merges the byte being accepted so the write can be issued on the same edge.
    always_comb begin
        word                   = asm_q;
        word[{idx, 3'b000} +: 8] = data;
        word_ready             = accept && !clear && (idx == IDX_W'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/table_loader.sv
// Streams bytes into the sine-table SRAM through port 0, one 32-bit word per 5 cycles at full rate.
module table_loader
    import table_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] num_words,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               csb0,
    output logic               web0,
    output logic [3:0]         wmask0,
    output logic [ADDR_W-1:0]  addr0,
    output logic [DATA_W-1:0]  din0,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               table_valid
);

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [COUNT_W-1:0] remaining;

    logic              accept;
    logic              clear;
    logic              word_ready;
    logic [DATA_W-1:0] word;

    assign accept = in_valid && in_ready && !abort;
    assign clear  = abort || ((state == IDLE) && start);

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .accept     (accept),
        .data       (in_data),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            in_ready    <= 1'b0;
            csb0        <= 1'b1;
            web0        <= 1'b1;
            wmask0      <= '0;
            addr0       <= '0;
            din0        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count_legal(num_words)) begin
                            addr        <= base_addr;
                            remaining   <= num_words;
                            table_valid <= 1'b0;
                            in_ready    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= COLLECT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (word_ready) begin
                        in_ready <= 1'b0;
                        csb0     <= 1'b0;
                        web0     <= 1'b0;
                        wmask0   <= '1;
                        addr0    <= addr;
                        din0     <= word;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    csb0 <= 1'b1;
                    web0 <= 1'b1;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == COUNT_W'(1)) begin
                            done        <= 1'b1;
                            table_valid <= 1'b1;
                            state       <= FINISH;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= COLLECT;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_table_loader.sv
// Randomised bench for table_loader: a byte-stream model predicts every SRAM write, checked each cycle.
module tb_table_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  num_words = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic        busy, done, err, table_valid;

    table_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .table_valid (table_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int write_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done_cyc = 0;

    wr_t         exp_q[$];
    wr_t         cur;
    logic [7:0]  stream[$];
    logic [7:0]  obs_a[$];
    logic [31:0] obs_d[$];
    int          obs_cyc[$];
    logic [7:0]  ref_a[$];
    logic [31:0] ref_d[$];
    logic [7:0]  hold_a = '0;
    logic [31:0] hold_d = '0;
    logic [3:0]  hold_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input int first);
        return {stream[first+3], stream[first+2], stream[first+1], stream[first]};
    endfunction

    // Every completed group of 4 bytes becomes one write at base + word index, modulo the table size.
    task automatic push_expect(input logic [7:0] base, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            wr_t e;
            e.a = base + 8'(w);
            e.d = pack(4 * w);
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            hold_a = '0;
            hold_d = '0;
            hold_m = '0;
        end else begin
            if (csb0 === 1'b0) begin
                chk("web0_in_write", web0, 1'b0);
                chk("wmask0_in_write", wmask0, 4'hF);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr0=%0h din0=%0h, expected no write (cycle %0d)",
                             addr0, din0, cyc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("addr0", addr0, cur.a);
                    chk("din0", din0, cur.d);
                end
                obs_a.push_back(addr0);
                obs_d.push_back(din0);
                obs_cyc.push_back(cyc);
                write_cnt++;
                hold_a = addr0;
                hold_d = din0;
                hold_m = wmask0;
            end else begin
                chk("csb0_known", csb0, 1'b1);
                chk("web0_idle", web0, 1'b1);
                chk("addr0_hold", addr0, hold_a);
                chk("din0_hold", din0, hold_d);
                chk("wmask0_hold", wmask0, hold_m);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err === 1'b1) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int first, input int count, input bit throttle);
        for (int i = first; i < first + count; i++) begin
            int w;
            if (throttle) repeat ($urandom_range(0, 3)) tick();
            in_valid = 1'b1;
            in_data  = stream[i];
            w = 0;
            while (in_ready !== 1'b1 && w < 40) begin
                tick();
                w++;
            end
            if (in_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 within 40 cycles", in_ready);
            end
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int maxc);
        int k = 0;
        while (done !== 1'b1 && k < maxc) begin
            tick();
            k++;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_d.delete();
        obs_cyc.delete();
    endtask

    task automatic random_stream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    int w0, d0, e0;
    logic [7:0] b;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_csb0", csb0, 1'b1);
        chk("rst_web0", web0, 1'b1);
        chk("rst_wmask0", wmask0, 4'h0);
        chk("rst_addr0", addr0, 8'h00);
        chk("rst_din0", din0, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_table_valid", table_valid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Full 256-word load with bytes 00..FF repeating
        stream.delete();
        for (int i = 0; i < 1024; i++) stream.push_back(8'(i));
        chk("model_first_word", pack(0), 32'h03020100);
        chk("model_last_word", pack(1020), 32'hFFFEFDFC);
        clear_obs();
        w0 = write_cnt;
        d0 = done_cnt;
        push_expect(8'h00, 256);
        do_start(8'h00, 9'd256);
        chk("full_busy", busy, 1'b1);
        feed(0, 1024, 1'b0);
        wait_done("full_done", 20);
        chk("full_table_valid_in_finish", table_valid, 1'b1);
        tick();
        chk("full_busy_after", busy, 1'b0);
        chk("full_writes", write_cnt - w0, 256);
        chk("full_first_addr", obs_a[0], 8'h00);
        chk("full_first_din", obs_d[0], 32'h03020100);
        chk("full_last_addr", obs_a[255], 8'hFF);
        chk("full_last_din", obs_d[255], 32'hFFFEFDFC);
        chk("full_write_period", obs_cyc[1] - obs_cyc[0], 5);
        chk("full_done_after_last", done_cyc - obs_cyc[255], 1);
        chk("full_done_count", done_cnt - d0, 1);
        chk("full_queue_empty", exp_q.size(), 0);

        // Address wrap-around, with a start pulse landing mid-load
        random_stream(12);
        clear_obs();
        d0 = done_cnt;
        push_expect(8'hFE, 3);
        do_start(8'hFE, 9'd3);
        feed(0, 2, 1'b0);
        do_start(8'h55, 9'd10);
        chk("busy_start_ignored", busy, 1'b1);
        feed(2, 10, 1'b0);
        wait_done("wrap_done", 20);
        tick();
        chk("wrap_count", obs_a.size(), 3);
        chk("wrap_addr0", obs_a[0], 8'hFE);
        chk("wrap_addr1", obs_a[1], 8'hFF);
        chk("wrap_addr2", obs_a[2], 8'h00);
        chk("wrap_done_count", done_cnt - d0, 1);
        chk("wrap_table_valid", table_valid, 1'b1);
        chk("wrap_queue_empty", exp_q.size(), 0);

        // Illegal word counts
        w0 = write_cnt;
        e0 = err_cnt;
        do_start(8'h20, 9'd0);
        chk("zero_err", err, 1'b1);
        chk("zero_busy", busy, 1'b0);
        tick();
        chk("zero_err_pulse", err, 1'b0);
        do_start(8'h20, 9'd257);
        chk("over_err", err, 1'b1);
        chk("over_busy", busy, 1'b0);
        repeat (3) tick();
        chk("illegal_no_writes", write_cnt - w0, 0);
        chk("illegal_err_count", err_cnt - e0, 2);
        chk("illegal_table_valid_kept", table_valid, 1'b1);

        // Abort after one full word and half of the next
        random_stream(8);
        b = 8'($urandom);
        w0 = write_cnt;
        d0 = done_cnt;
        push_expect(b, 1);
        do_start(b, 9'd2);
        feed(0, 6, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_table_valid", table_valid, 1'b0);
        repeat (8) tick();
        chk("abort_writes", write_cnt - w0, 1);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue_empty", exp_q.size(), 0);

        // Same 4 words unthrottled, then with random in_valid gaps
        random_stream(16);
        b = 8'($urandom);
        clear_obs();
        push_expect(b, 4);
        do_start(b, 9'd4);
        feed(0, 16, 1'b0);
        wait_done("plain_done", 20);
        tick();
        ref_a = obs_a;
        ref_d = obs_d;
        clear_obs();
        push_expect(b, 4);
        do_start(b, 9'd4);
        feed(0, 16, 1'b1);
        wait_done("throttle_done", 20);
        tick();
        chk("throttle_count", obs_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("throttle_addr", obs_a[i], ref_a[i]);
            chk("throttle_din", obs_d[i], ref_d[i]);
        end
        chk("throttle_queue_empty", exp_q.size(), 0);

        // Reset asserted during the WRITE cycle
        random_stream(8);
        w0 = write_cnt;
        do_start(8'h10, 9'd2);
        feed(0, 4, 1'b0);
        chk("pre_reset_csb0", csb0, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset_csb0", csb0, 1'b1);
        chk("reset_web0", web0, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) tick();
        chk("reset_no_writes", write_cnt - w0, 0);
        chk("reset_idle_busy", busy, 1'b0);
        chk("reset_table_valid", table_valid, 1'b0);
        chk("reset_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/table_loader.md
TABLE_LOADER -- requirements
Module: table_loader

Interface
REQ-001 SHALL have the port list: clk  in  1  rising-edge clock, shared with the sine-table SRAM and the phase counter.
REQ-002 SHALL have the port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have the ports: start  in  1  one-cycle pulse that begins a load; abort  in  1  cancels a load in progress.
REQ-004 SHALL have the ports: base_addr  in  8  first table address; num_words  in  9  word count, legal range 1..256.
REQ-005 SHALL have the ports: in_valid  in  1  byte-stream valid; in_data  in  8  byte-stream data; in_ready  out  1  byte accepted when in_valid and in_ready are both high.
REQ-006 SHALL have the SRAM port-0 drive ports: csb0  out  1  chip select, active-low; web0  out  1  write enable, active-low; wmask0  out  4; addr0  out  8; din0  out  32.
REQ-007 SHALL have the status ports: busy  out  1; done  out  1  one-cycle pulse; err  out  1  one-cycle pulse; table_valid  out  1  table fully loaded, used to gate SRAM read port 1.

Function
REQ-008 SHALL implement an FSM with the states IDLE, COLLECT, WRITE and FINISH.
REQ-009 IDLE, start=1, num_words in 1..256: latch base_addr and num_words, clear table_valid and the byte index, then enter COLLECT.
REQ-010 IDLE, start=1, num_words=0 or >256: pulse err for 1 cycle, remain in IDLE, and leave table_valid unchanged.
REQ-011 A start or abort pulse while not in IDLE or COLLECT SHALL be handled as follows: start is ignored outside IDLE; abort is honoured in COLLECT and WRITE.
REQ-012 COLLECT: in_ready=1, and each accepted byte k (k=0..3) SHALL be placed little-endian into the assembly register bits [8k+7:8k].
REQ-013 Acceptance of byte 3 SHALL move the FSM to WRITE on the next edge, with in_ready=0 in WRITE.
REQ-014 WRITE SHALL last exactly 1 cycle, with registered outputs csb0=0, web0=0, wmask0=4'hF, addr0=current address and din0=the assembled word.
REQ-015 Outside WRITE, csb0=1 and web0=1; wmask0, addr0 and din0 hold their last values.
REQ-016 After each write, the address SHALL increment modulo 256 (8'hFF wraps to 8'h00) and the remaining count SHALL decrement.
REQ-017 After a write with remaining count=1, the FSM SHALL enter FINISH; otherwise it SHALL return to COLLECT with byte index 0.
REQ-018 FINISH SHALL last 1 cycle: done=1, table_valid set, then return to IDLE.
REQ-019 Abort SHALL discard any partial word, suppress any pending write, leave table_valid=0, return to IDLE on the next edge, and pulse no done.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Sustained in_valid SHALL yield one write per 5 cycles; in_valid gaps only stall progress and lose no data.

Reset
REQ-022 Asynchronous reset SHALL force: state=IDLE, in_ready=0, csb0=1, web0=1, wmask0=0, addr0=0, din0=0, busy=0, done=0, err=0, table_valid=0, and clear the internal counters.
REQ-023 Reset asserted mid-load SHALL truncate any SRAM write in progress: csb0/web0 deassert immediately and no further write follows.

Structure
REQ-024 A shared package SHALL hold: the FSM state enum; TABLE_DEPTH=256; ADDR_W=8; DATA_W=32; BYTES_PER_WORD=4.
REQ-025 One sub-module SHALL be used: byte_packer, which owns the byte index, the assembly register and the word_ready strobe; the FSM, address and count logic stay in the top level.

Verification
REQ-026 The bench SHALL cover a full load: start, base_addr=0, num_words=256, bytes 00..FF repeating -> 256 writes, first din0=32'h03020100 at addr0=0, done after the last write, table_valid=1.
REQ-027 The bench SHALL cover wrap-around: base_addr=8'hFE, num_words=3 -> writes at addresses FE, FF, 00, then done.
REQ-028 The bench SHALL cover illegal counts: num_words=0 and num_words=257 -> err pulses, busy stays 0, no csb0 activity.
REQ-029 The bench SHALL cover abort: num_words=2, 6 bytes sent, then abort -> exactly 1 write, no done, table_valid=0, busy=0 on the next cycle.
REQ-030 The bench SHALL cover reset and start-while-busy: reset asserted in the WRITE cycle -> csb0=1 immediately, state IDLE; start while busy -> ignored, with the base address unchanged.
REQ-031 The bench SHALL cover throttled input: random in_valid gaps with num_words=4 -> the same 4 words written in order as with unthrottled input.
